// File: rtl/alu_issue_if.sv
`timescale 1ns/1ps
// Issue/writeback handshake bundle for alu_issue_stage: upstream op channel and
// downstream result channel. out_zero/out_neg exist only when ALU_FLAGS_EN is defined.
interface alu_issue_if #(parameter int TAG_W = 5);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [3:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
`ifdef ALU_FLAGS_EN
    logic             out_zero;
    logic             out_neg;
`endif

`ifdef ALU_FLAGS_EN
    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_illegal, out_zero, out_neg
    );
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_illegal, out_zero, out_neg
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_illegal
    );
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_illegal
    );
`endif
endinterface

// File: rtl/alu_issue_stage.sv
`timescale 1ns/1ps
// alu_issue_stage: two-stage valid/ready pipeline wrapped around the combinational 32-bit ALU.
// Optional macro ALU_FLAGS_EN adds registered out_zero/out_neg flags on the result channel.
module alu_issue_stage #(
    parameter int TAG_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    alu_issue_if.slave  bus,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_s3,
    output logic        alu_s2,
    output logic        alu_s1,
    output logic        alu_s0,
    input  logic [31:0] alu_c
);
    logic             vld_p1;
    logic             vld_p2;
    logic             ill_p1;
    logic [3:0]       sel_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             adv1;
    logic             adv2;
    logic             push_p1;
    logic             cap_p2;

    // Only these selects make the ALU drive c; everything else would leave it floating.
    function automatic logic op_illegal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b1000, 4'b1001,
            4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110: return 1'b0;
            default:                                     return 1'b1;
        endcase
    endfunction

    assign adv2         = !vld_p2 || bus.out_ready;
    assign adv1         = !vld_p1 || adv2;
    assign bus.in_ready = adv1;
    assign push_p1      = bus.in_valid && adv1 && !flush;
    assign cap_p2       = adv2 && vld_p1 && !flush;

    assign {alu_s3, alu_s2, alu_s1, alu_s0} = sel_p1;
    assign bus.out_valid = vld_p2;

    // ---- stage 1: operand register feeding the ALU ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            ill_p1 <= 1'b0;
            sel_p1 <= 4'b0000;
            tag_p1 <= '0;
            alu_a  <= 32'd0;
            alu_b  <= 32'd0;
        end else begin
            if (flush)
                vld_p1 <= 1'b0;
            else if (push_p1)
                vld_p1 <= 1'b1;
            else if (adv1)
                vld_p1 <= 1'b0;

            if (push_p1) begin
                alu_a  <= bus.in_a;
                alu_b  <= bus.in_b;
                tag_p1 <= bus.in_tag;
                ill_p1 <= op_illegal(bus.in_op);
                sel_p1 <= op_illegal(bus.in_op) ? 4'b0000 : bus.in_op;
            end
        end
    end

    // ---- stage 2: result register toward writeback ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2          <= 1'b0;
            bus.out_result  <= 32'd0;
            bus.out_tag     <= '0;
            bus.out_illegal <= 1'b0;
`ifdef ALU_FLAGS_EN
            bus.out_zero    <= 1'b0;
            bus.out_neg     <= 1'b0;
`endif
        end else begin
            if (flush)
                vld_p2 <= 1'b0;
            else if (cap_p2)
                vld_p2 <= 1'b1;
            else if (adv2)
                vld_p2 <= 1'b0;

            if (cap_p2) begin
                bus.out_result  <= ill_p1 ? 32'd0 : alu_c;
                bus.out_tag     <= tag_p1;
                bus.out_illegal <= ill_p1;
`ifdef ALU_FLAGS_EN
                bus.out_zero    <= ill_p1 ? 1'b1 : (alu_c == 32'd0);
                bus.out_neg     <= ill_p1 ? 1'b0 : alu_c[31];
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
`timescale 1ns/1ps
// Self-checking bench for alu_issue_stage: behavioural ALU, directed vector table,
// and hand-written sequences for throughput, backpressure, flush and async reset.
module tb_alu_issue_stage;
    localparam int TAG_W = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] alu_a, alu_b, alu_c;
    logic        alu_s3, alu_s2, alu_s1, alu_s0;
    logic [3:0]  alu_s;

    int errors = 0;
    int checks = 0;

    alu_issue_if #(.TAG_W(TAG_W)) bus ();

    alu_issue_stage #(.TAG_W(TAG_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .bus    (bus),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_s3 (alu_s3),
        .alu_s2 (alu_s2),
        .alu_s1 (alu_s1),
        .alu_s0 (alu_s0),
        .alu_c  (alu_c)
    );

    always #5 clk = ~clk;

    assign alu_s = {alu_s3, alu_s2, alu_s1, alu_s0};

    // Stand-in for the real ALU; unsupported selects yield a poison value.
    always_comb begin
        alu_c = 32'hDEAD_BEEF;
        case (alu_s)
            4'b0000: alu_c = alu_a + alu_b;
            4'b0001: alu_c = alu_a - alu_b;
            4'b1000: alu_c = alu_a & alu_b;
            4'b1001: alu_c = alu_a | alu_b;
            4'b1010: alu_c = alu_a ^ alu_b;
            4'b1011: alu_c = ~(alu_a ^ alu_b);
            4'b1100: alu_c = alu_a << alu_b[4:0];
            4'b1101: alu_c = alu_a >> alu_b[4:0];
            4'b1110: alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_c = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
        logic             ill;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic [TAG_W-1:0] tag);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_tag   = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_bb [3];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.in_op     = 4'd0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 4'b0000, 5'd7,  32'h0000_0008, 1'b0};
        vecs[1]  = '{32'h0000_000A, 32'h0000_0003, 4'b0001, 5'd1,  32'h0000_0007, 1'b0};
        vecs[2]  = '{32'h0000_0003, 32'h0000_000A, 4'b0001, 5'd2,  32'hFFFF_FFF9, 1'b0};
        vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 5'd3,  32'h0000_0000, 1'b0};
        vecs[4]  = '{32'h0000_00F0, 32'h0000_003C, 4'b1000, 5'd4,  32'h0000_0030, 1'b0};
        vecs[5]  = '{32'h0000_00F0, 32'h0000_000F, 4'b1001, 5'd5,  32'h0000_00FF, 1'b0};
        vecs[6]  = '{32'hFF00_FF00, 32'h0F0F_0F0F, 4'b1010, 5'd6,  32'hF00F_F00F, 1'b0};
        vecs[7]  = '{32'hFFFF_0000, 32'h0F0F_0F0F, 4'b1011, 5'd8,  32'h0F0F_F0F0, 1'b0};
        vecs[8]  = '{32'h0000_0001, 32'h0000_001F, 4'b1100, 5'd9,  32'h8000_0000, 1'b0};
        vecs[9]  = '{32'h8000_0000, 32'h0000_001F, 4'b1101, 5'd10, 32'h0000_0001, 1'b0};
        vecs[10] = '{32'h8000_0000, 32'h0000_0004, 4'b1110, 5'd11, 32'hF800_0000, 1'b0};
        vecs[11] = '{32'h0000_0001, 32'h0000_0001, 4'b0101, 5'd12, 32'h0000_0000, 1'b1};
        vecs[12] = '{32'h1234_5678, 32'h0000_0001, 4'b1111, 5'd13, 32'h0000_0000, 1'b1};
        vecs[13] = '{32'h8000_0000, 32'h8000_0000, 4'b0010, 5'd31, 32'h0000_0000, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_tag", {27'd0, bus.out_tag}, 32'd0);
        chk("rst_out_illegal", {31'd0, bus.out_illegal}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_s", {28'd0, alu_s}, 32'd0);
`ifdef ALU_FLAGS_EN
        chk("rst_out_zero", {31'd0, bus.out_zero}, 32'd0);
        chk("rst_out_neg", {31'd0, bus.out_neg}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed vectors, one op at a time
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag);
            chk($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_alu_s", i), {28'd0, alu_s},
                vecs[i].ill ? 32'd0 : {28'd0, vecs[i].op});
            chk($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].a);
            tick();
            chk($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("vec%0d_result", i), bus.out_result, vecs[i].res);
            chk($sformatf("vec%0d_tag", i), {27'd0, bus.out_tag}, {27'd0, vecs[i].tag});
            chk($sformatf("vec%0d_illegal", i), {31'd0, bus.out_illegal}, {31'd0, vecs[i].ill});
`ifdef ALU_FLAGS_EN
            chk($sformatf("vec%0d_zero", i), {31'd0, bus.out_zero},
                {31'd0, vecs[i].res == 32'd0});
            chk($sformatf("vec%0d_neg", i), {31'd0, bus.out_neg}, {31'd0, vecs[i].res[31]});
`endif
        end
        tick();
        chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Back-to-back throughput: sub, xor, sra
        exp_bb[0] = 32'h0000_0007;
        exp_bb[1] = 32'hF00F_F00F;
        exp_bb[2] = 32'hF800_0000;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: drive(32'h0000_000A, 32'h0000_0003, 4'b0001, 5'd20);
                1: drive(32'hFF00_FF00, 32'h0F0F_0F0F, 4'b1010, 5'd21);
                2: drive(32'h8000_0000, 32'h0000_0004, 4'b1110, 5'd22);
                default: bus.in_valid = 1'b0;
            endcase
            if (k < 3) chk($sformatf("b2b%0d_in_ready", k), {31'd0, bus.in_ready}, 32'd1);
            tick();
            if (k >= 1) begin
                chk($sformatf("b2b%0d_out_valid", k - 1), {31'd0, bus.out_valid}, 32'd1);
                chk($sformatf("b2b%0d_result", k - 1), bus.out_result, exp_bb[k - 1]);
                chk($sformatf("b2b%0d_tag", k - 1), {27'd0, bus.out_tag}, 32'd20 + k - 1);
            end
        end
        tick();
        chk("b2b_drain", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: result holds, stage 1 stalls, nothing lost
        bus.out_ready = 1'b0;
        drive(32'h0000_00F0, 32'h0000_003C, 4'b1000, 5'd1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("bp_first_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_first_result", bus.out_result, 32'h0000_0030);
        drive(32'h0000_000F, 32'h0000_00F0, 4'b1001, 5'd2);
        chk("bp_accept_second", {31'd0, bus.in_ready}, 32'd1);
        tick();
        drive(32'h0000_0001, 32'h0000_0001, 4'b0000, 5'd3);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_stall%0d_in_ready", c), {31'd0, bus.in_ready}, 32'd0);
            chk($sformatf("bp_stall%0d_result", c), bus.out_result, 32'h0000_0030);
            chk($sformatf("bp_stall%0d_tag", c), {27'd0, bus.out_tag}, 32'd1);
            chk($sformatf("bp_stall%0d_alu_a", c), alu_a, 32'h0000_000F);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_second_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_second_result", bus.out_result, 32'h0000_00FF);
        chk("bp_second_tag", {27'd0, bus.out_tag}, 32'd2);
        tick();
        chk("bp_third_result", bus.out_result, 32'h0000_0002);
        chk("bp_third_tag", {27'd0, bus.out_tag}, 32'd3);
        tick();
        chk("bp_drain", {31'd0, bus.out_valid}, 32'd0);

        // Flush: alone with both stages full, then together with a push
        bus.out_ready = 1'b0;
        drive(32'h0000_0001, 32'h0000_0002, 4'b0000, 5'd4);
        tick();
        drive(32'h0000_0002, 32'h0000_0002, 4'b0000, 5'd5);
        tick();
        bus.in_valid = 1'b0;
        chk("fl_full_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("fl_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        flush = 1'b1;
        tick();
        chk("fl_alone_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("fl_alone_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        drive(32'h0000_0007, 32'h0000_0007, 4'b0000, 5'd6);
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_push_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk("fl_dropped_op", {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk("fl_dropped_op2", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset between edges with both stages occupied
        bus.out_ready = 1'b0;
        drive(32'h0000_0010, 32'h8000_0000, 4'b0001, 5'd9);
        tick();
        drive(32'h0000_0003, 32'h0000_0004, 4'b0000, 5'd10);
        tick();
        bus.in_valid = 1'b0;
        chk("ar_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("ar_pre_result", bus.out_result, 32'h8000_0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("ar_out_result", bus.out_result, 32'd0);
        chk("ar_out_tag", {27'd0, bus.out_tag}, 32'd0);
        chk("ar_out_illegal", {31'd0, bus.out_illegal}, 32'd0);
        chk("ar_alu_a", alu_a, 32'd0);
        chk("ar_alu_b", alu_b, 32'd0);
`ifdef ALU_FLAGS_EN
        chk("ar_out_neg", {31'd0, bus.out_neg}, 32'd0);
`endif
        #1;
        rst_n = 1'b1;
        #1;
        chk("ar_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("ar_post_valid", {31'd0, bus.out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
